output_classifier: RTL and testbench
====================================

# output_classifier

Sequential consumer on the output side of the final `layer` instance. It waits for the layer's `ready` to rise, then snapshots the signed fixed-point activation vector. It scans the vector one element per clock to find the winning class (argmax) and presents the class index, the winning activation and a one-cycle `valid` pulse to the host or display logic. It is the reader for the layer's `out`/`ready` interface.

## Interface
- `bits`, 16, activation word width, signed two's complement
- `fractional_bits`, 11, fractional bits of the Q format; carried for the margin output only and does not affect comparisons
- `size`, 10, number of activations (output-layer neurons); must be ≥ 2
- `IDX_W`, `$clog2(size)`, width of class index (derived; do not override)

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `ready`  in  1  layer-done level from `layer`
- `in`  in  `bits` × [0:size-1]  signed activation array, valid while `ready` high
- `class`  out  IDX_W  index of maximum activation
- `max_value`  out  `bits` signed  activation at `class`
- `valid`  out  1  one-cycle pulse, result fields valid
- `busy`  out  1  high in CAPTURE/SCAN
- `overrun`  out  1  sticky; `ready` rose while busy
- `margin`  out  `bits`  max minus second max (only with CLASSIFIER_MARGIN_EN)

## Operation
- Registered `ready_q` detects the rising edge: `ready & ~ready_q`. `ready_q` resets to 0, so `ready` already high in the first post-reset cycle counts as an edge.
- FSM states and transitions:
  - IDLE: on edge, go to CAPTURE.
  - CAPTURE: copy `in[0..size-1]` into `snap`; set `best_idx`=0 and `best_val`=`in[0]`; set index counter `i`=1; go to SCAN.
  - SCAN: compare `snap[i]` against `best_val`. If `snap[i] > best_val` (strict signed comparison), update `best_idx`/`best_val`. If `i == size-1`, go to DONE; otherwise increment `i`.
  - DONE: load `class`/`max_value` from best; pulse `valid`; return to IDLE.
- Ties resolve to the lowest index.
- Comparisons are full-width signed; no rounding or saturation.
- `class`/`max_value` hold their last result until the next DONE.
- An edge seen in CAPTURE, SCAN or DONE is not queued. It sets `overrun`, which clears only on `reset`. The scan in progress uses the original snapshot.
- The snapshot decouples the block from `in`: `in` may change after CAPTURE without affecting the result.

## Timing
- Reset values: `class`=0, `max_value`=0, `valid`=0, `busy`=0, `overrun`=0, `margin`=0; state IDLE; `ready_q`=0.
- Latency: edge cycle T is sampled in IDLE. CAPTURE runs at T+1 and SCAN at T+2 … T+size. `valid` is high during cycle T+size+1 and `class` is updated in that same cycle. Total latency is size+1 cycles (11 with the default).
- Minimum spacing between accepted edges is size+2 cycles.
- `reset` asserted in any state aborts the scan the next edge: no `valid` and all outputs return to reset values.
- `ready` falling mid-scan has no effect.

## Configuration
- `CLASSIFIER_MARGIN_EN` defined:
  - Tracks `second_val` alongside best.
  - On a new max, `second_val` takes the old best; otherwise `second_val` takes `snap[i]` when it is greater than `second_val`.
  - `margin` = `best_val - second_val`, saturated to the positive signed max, and updated with `valid`.
- Undefined: no second-best tracking; `margin` is tied to 0. All other behaviour is identical.

## Test plan
- Basic argmax, Q5.11: `in` = {0x0100, 0x0200, 0x0E00, 0x0080, 0 …}, raise `ready` → `valid` pulses exactly 11 cycles after the edge cycle, `class`=2, `max_value`=0x0E00; with the macro, `margin`=0x0C00.
- Negatives and tie: all entries 0xF800 (−1.0) except idx 4 and idx 7 = 0xFC00 → `class`=4, `max_value`=0xFC00.
- Snapshot isolation: after CAPTURE, change `in[9]` to 0x7FFF → `class` is unaffected (prior winner reported).
- Overrun: lower then re-raise `ready` 3 cycles into SCAN → `overrun`=1, exactly one `valid`, result from the first vector.
- Reset mid-scan: assert `reset` at SCAN i=5 for 1 cycle → no `valid`, all outputs 0. A subsequent edge with index 9 max → `class`=9 after 11 cycles.
- Held `ready`: `ready` high through reset release → exactly one `valid`, none repeated while `ready` stays high.

Source files
------------

// File: rtl/output_classifier.sv
// Argmax reader for the final layer: snapshots the activation vector on a ready edge and scans it one element per clock.
// Optional CLASSIFIER_MARGIN_EN adds second-best tracking and a saturated best-minus-second margin output.
module output_classifier #(
    parameter  int bits            = 16,
    parameter  int fractional_bits = 11,
    parameter  int size            = 10,
    localparam int IDX_W           = $clog2(size)
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   ready_i,
    input  logic signed [bits-1:0] in_i [0:size-1],
    output logic [IDX_W-1:0]       class_o,
    output logic signed [bits-1:0] max_value_o,
    output logic                   valid_o,
    output logic                   busy_o,
    output logic                   overrun_o,
    output logic [bits-1:0]        margin_o
);

    if (size < 2 || fractional_bits < 0 || fractional_bits >= bits) begin : g_bad_params
        $error("output_classifier: size must be >= 2 and fractional_bits must lie in [0, bits)");
    end

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SCAN,
        DONE
    } state_t;

    state_t                 state_q;
    logic                   ready_q;
    logic signed [bits-1:0] snap_q [0:size-1];
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       best_idx_q;
    logic signed [bits-1:0] best_val_q;
    logic [IDX_W-1:0]       class_q;
    logic signed [bits-1:0] max_value_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   overrun_q;

    logic                   rise;
    logic signed [bits-1:0] cur;
    logic                   take;
    logic [IDX_W-1:0]       best_idx_d;
    logic signed [bits-1:0] best_val_d;

    assign rise = ready_i & ~ready_q;

    always_comb begin
        cur        = snap_q[idx_q];
        take       = cur > best_val_q;
        best_idx_d = take ? idx_q : best_idx_q;
        best_val_d = take ? cur : best_val_q;
    end

`ifdef CLASSIFIER_MARGIN_EN
    logic signed [bits-1:0] second_val_q;
    logic signed [bits-1:0] second_val_d;
    logic [bits:0]          diff;
    logic [bits-1:0]        margin_d;
    logic [bits-1:0]        margin_q;

    // best >= second always holds, so the only overflow is past the positive max
    always_comb begin
        if (take) begin
            second_val_d = best_val_q;
        end else if (cur > second_val_q) begin
            second_val_d = cur;
        end else begin
            second_val_d = second_val_q;
        end
        diff     = {best_val_d[bits-1], best_val_d} - {second_val_d[bits-1], second_val_d};
        margin_d = (diff[bits] ^ diff[bits-1]) ? {1'b0, {(bits-1){1'b1}}} : diff[bits-1:0];
    end

    assign margin_o = margin_q;
`else
    assign margin_o = '0;
`endif

    always_ff @(posedge clock_i) begin
        if (state_q == CAPTURE) begin
            snap_q <= in_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_val_q  <= '0;
            class_q     <= '0;
            max_value_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef CLASSIFIER_MARGIN_EN
            second_val_q <= '0;
            margin_q     <= '0;
`endif
        end else begin
            ready_q <= ready_i;
            valid_q <= 1'b0;
            // Edges arriving while a vector is in flight are dropped, not queued
            if (rise && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    best_idx_q <= '0;
                    best_val_q <= in_i[0];
                    idx_q      <= IDX_W'(1);
`ifdef CLASSIFIER_MARGIN_EN
                    second_val_q <= {1'b1, {(bits-1){1'b0}}};
`endif
                    state_q    <= SCAN;
                end
                SCAN: begin
                    best_idx_q <= best_idx_d;
                    best_val_q <= best_val_d;
`ifdef CLASSIFIER_MARGIN_EN
                    second_val_q <= second_val_d;
`endif
                    if (idx_q == IDX_W'(size - 1)) begin
                        class_q     <= best_idx_d;
                        max_value_q <= best_val_d;
                        valid_q     <= 1'b1;
                        busy_q      <= 1'b0;
`ifdef CLASSIFIER_MARGIN_EN
                        margin_q    <= margin_d;
`endif
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign class_o     = class_q;
    assign max_value_o = max_value_q;
    assign valid_o     = valid_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_output_classifier.sv
// Directed bench for output_classifier with hand-computed expectations.
// Margin expectations switch with CLASSIFIER_MARGIN_EN.
module tb_output_classifier;

    logic               clock_i;
    logic               reset_i;
    logic               ready_i;
    logic signed [15:0] inVec [0:9];
    logic [3:0]         classOut;
    logic [15:0]        maxValue;
    logic               validOut;
    logic               busyOut;
    logic               overrunOut;
    logic [15:0]        marginOut;

    int checks = 0;
    int errors = 0;

    output_classifier dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .ready_i    (ready_i),
        .in_i       (inVec),
        .class_o    (classOut),
        .max_value_o(maxValue),
        .valid_o    (validOut),
        .busy_o     (busyOut),
        .overrun_o  (overrunOut),
        .margin_o   (marginOut)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

`ifdef CLASSIFIER_MARGIN_EN
    localparam logic [15:0] MARGIN_BASIC = 16'h0C00;
    localparam logic [15:0] MARGIN_IDX9  = 16'h0100;
    localparam logic [15:0] MARGIN_HELD  = 16'h0150;
    localparam logic [15:0] MARGIN_SAT   = 16'h7FFF;
`else
    localparam logic [15:0] MARGIN_BASIC = 16'h0000;
    localparam logic [15:0] MARGIN_IDX9  = 16'h0000;
    localparam logic [15:0] MARGIN_HELD  = 16'h0000;
    localparam logic [15:0] MARGIN_SAT   = 16'h0000;
`endif

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic fillVec(input logic [15:0] fill);
        for (int j = 0; j < 10; j++) inVec[j] = fill;
    endtask

    // Drop ready for a cycle so the next raise is a fresh edge; the caller's vector is already loaded
    task automatic applyStimulus();
        ready_i = 1'b0;
        tick();
        ready_i = 1'b1;
    endtask

    // Mode 1: corrupt in[9] after capture; mode 2: re-raise ready mid-scan; mode 3: reset at SCAN i=5
    task automatic runScan(input int mode, input int nCycles, output int firstValid, output int nValid,
                           output logic busyAtCapture);
        firstValid    = -1;
        nValid        = 0;
        busyAtCapture = 1'b0;
        for (int k = 1; k <= nCycles; k++) begin
            tick();
            if (validOut === 1'b1) begin
                nValid++;
                if (firstValid < 0) firstValid = k;
            end
            if (k == 1) busyAtCapture = busyOut;
            if (mode == 1 && k == 2) inVec[9] = 16'sh7FFF;
            if (mode == 2 && k == 5) ready_i = 1'b0;
            if (mode == 2 && k == 6) begin
                ready_i = 1'b1;
                fillVec(16'h0000);
                inVec[1] = 16'sh0700;
            end
            if (mode == 3 && k == 6) begin
                reset_i = 1'b1;
                ready_i = 1'b0;
            end
            if (mode == 3 && k == 7) reset_i = 1'b0;
        end
    endtask

    int   firstValid;
    int   nValid;
    logic busyCap;

    initial begin
        reset_i = 1'b1;
        ready_i = 1'b0;
        fillVec(16'h0000);
        repeat (3) tick();
        checkOutput("reset_class", 32'(classOut), 32'h0);
        checkOutput("reset_max", 32'(maxValue), 32'h0);
        checkOutput("reset_valid", 32'(validOut), 32'h0);
        checkOutput("reset_busy", 32'(busyOut), 32'h0);
        checkOutput("reset_overrun", 32'(overrunOut), 32'h0);
        checkOutput("reset_margin", 32'(marginOut), 32'h0);
        reset_i = 1'b0;
        tick();

        $display("[TB] basic argmax");
        fillVec(16'h0000);
        inVec[0] = 16'sh0100;
        inVec[1] = 16'sh0200;
        inVec[2] = 16'sh0E00;
        inVec[3] = 16'sh0080;
        applyStimulus();
        runScan(0, 14, firstValid, nValid, busyCap);
        checkOutput("basic_latency", 32'(firstValid), 32'd11);
        checkOutput("basic_nvalid", 32'(nValid), 32'd1);
        checkOutput("basic_busy_capture", 32'(busyCap), 32'h1);
        checkOutput("basic_class", 32'(classOut), 32'h2);
        checkOutput("basic_max", 32'(maxValue), 32'h0E00);
        checkOutput("basic_margin", 32'(marginOut), 32'(MARGIN_BASIC));

        $display("[TB] negatives with tie");
        fillVec(16'hF800);
        inVec[4] = 16'shFC00;
        inVec[7] = 16'shFC00;
        applyStimulus();
        runScan(0, 14, firstValid, nValid, busyCap);
        checkOutput("tie_latency", 32'(firstValid), 32'd11);
        checkOutput("tie_class", 32'(classOut), 32'h4);
        checkOutput("tie_max", 32'(maxValue), 32'hFC00);
        checkOutput("tie_margin", 32'(marginOut), 32'h0);

        $display("[TB] snapshot isolation");
        fillVec(16'h0000);
        inVec[0] = 16'sh0100;
        inVec[1] = 16'sh0200;
        inVec[2] = 16'sh0E00;
        inVec[3] = 16'sh0080;
        applyStimulus();
        runScan(1, 14, firstValid, nValid, busyCap);
        checkOutput("snap_class", 32'(classOut), 32'h2);
        checkOutput("snap_max", 32'(maxValue), 32'h0E00);

        $display("[TB] overrun");
        fillVec(16'h0010);
        inVec[6] = 16'sh0400;
        applyStimulus();
        runScan(2, 20, firstValid, nValid, busyCap);
        checkOutput("ovr_flag", 32'(overrunOut), 32'h1);
        checkOutput("ovr_nvalid", 32'(nValid), 32'd1);
        checkOutput("ovr_latency", 32'(firstValid), 32'd11);
        checkOutput("ovr_class", 32'(classOut), 32'h6);
        checkOutput("ovr_max", 32'(maxValue), 32'h0400);
        ready_i = 1'b0;
        tick();

        $display("[TB] reset mid-scan");
        fillVec(16'h0001);
        inVec[5] = 16'sh0500;
        applyStimulus();
        runScan(3, 14, firstValid, nValid, busyCap);
        checkOutput("rst_nvalid", 32'(nValid), 32'd0);
        checkOutput("rst_class", 32'(classOut), 32'h0);
        checkOutput("rst_max", 32'(maxValue), 32'h0);
        checkOutput("rst_valid", 32'(validOut), 32'h0);
        checkOutput("rst_busy", 32'(busyOut), 32'h0);
        checkOutput("rst_overrun", 32'(overrunOut), 32'h0);
        checkOutput("rst_margin", 32'(marginOut), 32'h0);
        fillVec(16'h0001);
        inVec[0] = 16'sh0200;
        inVec[9] = 16'sh0300;
        applyStimulus();
        runScan(0, 14, firstValid, nValid, busyCap);
        checkOutput("idx9_latency", 32'(firstValid), 32'd11);
        checkOutput("idx9_class", 32'(classOut), 32'h9);
        checkOutput("idx9_max", 32'(maxValue), 32'h0300);
        checkOutput("idx9_margin", 32'(marginOut), 32'(MARGIN_IDX9));

        $display("[TB] ready held through reset release");
        fillVec(16'hFF00);
        inVec[3] = 16'sh0050;
        reset_i = 1'b1;
        ready_i = 1'b1;
        repeat (3) tick();
        reset_i = 1'b0;
        runScan(0, 30, firstValid, nValid, busyCap);
        checkOutput("held_nvalid", 32'(nValid), 32'd1);
        checkOutput("held_latency", 32'(firstValid), 32'd11);
        checkOutput("held_class", 32'(classOut), 32'h3);
        checkOutput("held_overrun", 32'(overrunOut), 32'h0);
        checkOutput("held_margin", 32'(marginOut), 32'(MARGIN_HELD));

        $display("[TB] extreme values and margin saturation");
        fillVec(16'h8000);
        inVec[1] = 16'sh7FFF;
        applyStimulus();
        runScan(0, 14, firstValid, nValid, busyCap);
        checkOutput("sat_class", 32'(classOut), 32'h1);
        checkOutput("sat_max", 32'(maxValue), 32'h7FFF);
        checkOutput("sat_margin", 32'(marginOut), 32'(MARGIN_SAT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
